rr_merge2: RTL and testbench
============================

// Module: rr_merge2
// PURPOSE
//   Two-channel round-robin arbiter/merger that sits directly upstream of the 2:1 datapath mux.
//   It picks one of two valid/ready request streams each cycle and drives the mux select.
//   The granted word is captured in a one-entry output register, with its source tag.
//   Sits between two producer stages and a single shared consumer stage.
// PARAMETERS
//   WIDTH   8   data width of each input channel and of the output
//   CNT_W   8   width of grant counters (used only when ARB_CNT_EN is defined)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   in0_valid  in   1      channel 0 has a word
//   in0_data   in   WIDTH  channel 0 word
//   in0_ready  out  1      channel 0 word accepted this cycle
//   in1_valid  in   1      channel 1 has a word
//   in1_data   in   WIDTH  channel 1 word
//   in1_ready  out  1      channel 1 word accepted this cycle
//   sel        out  1      combinational grant: 0=ch0, 1=ch1; drives the downstream 2:1 mux select
//   out_valid  out  1      output register holds a word
//   out_data   out  WIDTH  registered granted word
//   out_src    out  1      source channel of out_data
//   out_ready  in   1      consumer accepts the output word
//   gnt_cnt0   out  CNT_W  ch0 transfers accepted (ARB_CNT_EN only)
//   gnt_cnt1   out  CNT_W  ch1 transfers accepted (ARB_CNT_EN only)
// BEHAVIOUR
//   - Reset (rst=1 at clk edge): out_valid=0, out_data=0, out_src=0, last_src=1 (ch0 wins first tie).
//     gnt_cnt0/1 also reset to 0. Reset overrides every other event in the same cycle.
//   - load = ~out_valid | out_ready. The output register takes a new word only when load=1.
//   - Grant, combinational:
//       only in0_valid -> sel=0; only in1_valid -> sel=1;
//       both valid -> sel=~last_src; neither -> sel=last_src (hold, no transfer).
//   - in0_ready = load & in0_valid & (sel==0); in1_ready = load & in1_valid & (sel==1).
//     At most one ready is high per cycle. Ready never depends on the same-cycle ready of the other channel.
//   - Transfer (any ready high), at the next edge:
//       out_data<=granted data, out_src<=sel, out_valid<=1, last_src<=sel.
//   - Drain without refill (load=1, no input valid): out_valid<=0; out_data and out_src hold.
//   - Stall (out_valid=1, out_ready=0): out_data, out_src and out_valid hold stable, both readys stay 0.
//     last_src does not change.
//   - Simultaneous drain and refill: out_ready=1 with a granted input gives back-to-back words, no bubble.
//     This sustains 1 word/cycle.
//   - Latency: an input accepted at edge N appears on out_data after edge N (1 cycle).
//   - Fairness: under continuous dual requests with out_ready=1, grants alternate 0,1,0,1...
//     Neither channel waits more than 1 transfer.
//   - A granted input's data is captured only on its ready cycle. Producers must hold valid/data until ready.
// CONFIGURATION
//   ARB_CNT_EN defined: gnt_cnt0/gnt_cnt1 ports exist.
//     Each counter increments by 1 on a transfer from its channel and saturates at 2^CNT_W-1 (no wrap).
//     Reset clears both counters.
//   ARB_CNT_EN undefined: counter ports and logic are absent. All other behaviour is identical.
// TESTING
//   1 Reset: rst=1 for 2 cycles with both valids=1 -> out_valid=0, out_data=0, both readys 0 during reset.
//   2 Tie and alternation: both valid, in0_data=8'hA0, in1_data=8'hB1, out_ready=1 for 4 cycles
//     -> out_src sequence 0,1,0,1, out_data A0,B1,A0,B1.
//   3 Stall: load 8'h5C from ch1, then out_ready=0 for 3 cycles with both valid
//     -> out_data=8'h5C held, in0_ready=in1_ready=0; release -> ch0 granted next.
//   4 Single requester: only in1_valid, 3 words 8'h01,02,03, out_ready=1
//     -> sel=1 each cycle, out_data 01,02,03 back-to-back, no bubble.
//   5 Mid-operation reset: out_valid=1 holding 8'h77, assert rst with out_ready=0
//     -> next cycle out_valid=0; after release, first tie goes to ch0.
//   6 ARB_CNT_EN, CNT_W=2: 5 ch0 transfers -> gnt_cnt0=3 (saturated), gnt_cnt1=0.

Source files
------------

// File: rtl/rr_merge2.sv
// rr_merge2: two-channel round-robin merger into a one-entry output register with source tag; defining ARB_CNT_EN adds saturating grant counters
module rr_merge2 #(
  parameter int WIDTH = 8
`ifdef ARB_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready
`ifdef ARB_CNT_EN
  , output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);
  logic             valid_q, src_q, last_q, load;
  logic [WIDTH-1:0] data_q;
  always_comb begin
    load      = ~valid_q | out_ready;
    sel       = (in0_valid & in1_valid) ? ~last_q : (in0_valid | in1_valid) ? in1_valid : last_q;
    in0_ready = ~rst & load & in0_valid & ~sel;
    in1_ready = ~rst & load & in1_valid & sel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
    end else if (in0_ready | in1_ready) begin
      valid_q <= 1'b1;
      data_q  <= sel ? in1_data : in0_data;
      src_q   <= sel;
      last_q  <= sel;
    end else if (load) begin
      valid_q <= 1'b0;
    end
  end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
`ifdef ARB_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (in0_ready && !(&cnt0_q)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (in1_ready && !(&cnt1_q)) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end
  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_rr_merge2.sv
// tb_rr_merge2: self-checking bench for rr_merge2 against a behavioural model
module tb_rr_merge2;
  localparam int W    = 8;
  localparam int CMAX = 3;
`ifdef ARB_CNT_EN
  localparam int CW = 2;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;
`endif
  logic         clk = 0, rst = 1, in0_valid = 0, in1_valid = 0, out_ready = 0;
  logic [W-1:0] in0_data = '0, in1_data = '0;
  logic         in0_ready, in1_ready, sel, out_valid, out_src;
  logic [W-1:0] out_data;
  int           n_chk = 0, n_fail = 0;
  bit           started = 0;
  logic         m_valid, m_src, m_last;
  logic [W-1:0] m_data;
  int           mc0, mc1;
  logic         e_sel = 0, e_r0 = 0, e_r1 = 0;
  always #5 clk = ~clk;
  rr_merge2 #(
    .WIDTH(W)
`ifdef ARB_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
`ifdef ARB_CNT_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Favour the channel that did not win last; with no requester the grant just points at the last winner.
  task automatic expect_now(output logic s, output logic r0, output logic r1);
    logic [1:0] req;
    int         fav;
    bit         busy;
    req  = {in1_valid, in0_valid};
    fav  = m_last ? 0 : 1;
    busy = m_valid && !out_ready;
    s    = req[fav] ? fav[0] : (req[1-fav] ? ~fav[0] : m_last);
    r0   = !rst && !busy && req[0] && (s == 1'b0);
    r1   = !rst && !busy && req[1] && (s == 1'b1);
  endtask
  always @(posedge clk) begin
    logic s, r0, r1;
    expect_now(s, r0, r1);
    if (rst) begin
      m_valid = 0; m_data = '0; m_src = 0; m_last = 1; mc0 = 0; mc1 = 0;
    end else if (r0 || r1) begin
      m_valid = 1;
      m_data  = r1 ? in1_data : in0_data;
      m_src   = s;
      m_last  = s;
      if (r0 && mc0 < CMAX) mc0++;
      if (r1 && mc1 < CMAX) mc1++;
    end else if (!m_valid || out_ready) begin
      m_valid = 0;
    end
  end
  always @(negedge clk) begin
    if (started) begin
      expect_now(e_sel, e_r0, e_r1);
      chk("sel", sel, e_sel);
      chk("in0_ready", in0_ready, e_r0);
      chk("in1_ready", in1_ready, e_r1);
      chk("out_valid", out_valid, m_valid);
      chk("out_data", out_data, m_data);
      chk("out_src", out_src, m_src);
`ifdef ARB_CNT_EN
      chk("gnt_cnt0", gnt_cnt0, mc0);
      chk("gnt_cnt1", gnt_cnt1, mc1);
`endif
    end
  end
  initial begin
    in0_valid = 1; in1_valid = 1; in0_data = 8'hA0; in1_data = 8'hB1; rst = 1;
    @(posedge clk);
    started = 1;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_r0", in0_ready, 0);
    chk("rst_r1", in1_ready, 0);
    @(posedge clk); #1;
    rst = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("tie_src", out_src, i[0]);
      chk("tie_data", out_data, i[0] ? 8'hB1 : 8'hA0);
    end
    @(posedge clk); #1;
    in0_valid = 0; in1_data = 8'h5C;
    @(posedge clk); #1;
    in0_valid = 1; out_ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_data", out_data, 8'h5C);
      chk("stall_src", out_src, 1);
      chk("stall_r0", in0_ready, 0);
      chk("stall_r1", in1_ready, 0);
      @(posedge clk);
    end
    #1 out_ready = 1;
    @(negedge clk);
    chk("release_sel", sel, 0);
    chk("release_r0", in0_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("release_src", out_src, 0);
    chk("release_data", out_data, 8'hA0);
    @(posedge clk); #1;
    in0_valid = 0; in1_valid = 1;
    for (int k = 1; k <= 3; k++) begin
      in1_data = 8'(k);
      @(negedge clk);
      chk("single_sel", sel, 1);
      chk("single_r1", in1_ready, 1);
      if (k > 1) begin
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, k - 1);
      end
      @(posedge clk); #1;
    end
    in1_valid = 0;
    @(negedge clk);
    chk("single_last_valid", out_valid, 1);
    chk("single_last_data", out_data, 8'h03);
    @(posedge clk); #1;
    in0_valid = 1; in0_data = 8'h77;
    @(posedge clk); #1;
    in0_valid = 0; out_ready = 0; rst = 1;
    @(negedge clk);
    chk("mid_hold_data", out_data, 8'h77);
    chk("mid_hold_valid", out_valid, 1);
    @(posedge clk); #1;
    rst = 0; in0_valid = 1; in1_valid = 1; out_ready = 1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_tie_sel", sel, 0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_src", out_src, 0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 199) == 0);
      if (e_r0 || !in0_valid) begin
        in0_valid = ($urandom_range(0, 3) != 0);
        in0_data  = 8'($urandom);
      end
      if (e_r1 || !in1_valid) begin
        in1_valid = ($urandom_range(0, 3) != 0);
        in1_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
`ifdef ARB_CNT_EN
    @(posedge clk); #1;
    rst = 1; in0_valid = 0; in1_valid = 0;
    @(posedge clk); #1;
    rst = 0; in0_valid = 1; out_ready = 1;
    repeat (5) @(posedge clk);
    #1 in0_valid = 0;
    @(negedge clk);
    chk("cnt0_sat", gnt_cnt0, 3);
    chk("cnt1_zero", gnt_cnt1, 0);
`endif
    @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
